mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 32, address width of all ports.
REQ-002 Parameter: DATA_W, default 32, data width of all ports.
REQ-003 Parameter: MAX_WAIT, default 4, number of consecutive ungranted DMA-pending cycles before DMA gains priority over CPU; legal range 1..15.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 cpu_read  input  1  CPU MEM-stage load request, valid for the current cycle.
REQ-007 cpu_write  input  1  CPU MEM-stage store request, valid for the current cycle.
REQ-008 cpu_addr  input  ADDR_W  CPU access address.
REQ-009 cpu_wdata  input  DATA_W  CPU store data.
REQ-010 cpu_rdata  output  DATA_W  CPU load data, combinational from mem_rdata when CPU is granted, else 0.
REQ-011 cpu_stall  output  1  CPU access not serviced this cycle; pipeline holds PC, IF/ID, ID/EX and EX/MEM.
REQ-012 dma_req  input  1  DMA/loader request; held high with stable dma_we/addr/wdata until dma_ack.
REQ-013 dma_we  input  1  1 = DMA write, 0 = DMA read.
REQ-014 dma_addr  input  ADDR_W  DMA access address.
REQ-015 dma_wdata  input  DATA_W  DMA write data.
REQ-016 dma_rdata  output  DATA_W  registered DMA read data, valid while dma_ack high.
REQ-017 dma_ack  output  1  registered one-cycle completion pulse for a DMA access.
REQ-018 mem_read / mem_write  output  1 each  memory strobes; never both high.
REQ-019 mem_addr / mem_wdata  output  ADDR_W / DATA_W  memory address and write data, muxed from granted port, 0 when idle.
REQ-020 mem_rdata  input  DATA_W  combinational read data from data memory (same-cycle read, write on clock edge).

Function
REQ-021 Every access takes exactly one memory cycle; at most one port is granted per cycle (grant is combinational from inputs and registered state).
REQ-022 FSM states: IDLE, DMA_ACK; DMA_ACK lasts exactly one cycle then returns to IDLE.
REQ-023 In IDLE with only CPU requesting (cpu_read|cpu_write): CPU granted, cpu_stall=0.
REQ-024 In IDLE with only dma_req: DMA granted, next state DMA_ACK.
REQ-025 In IDLE with both requesting and wait_cnt < MAX_WAIT: CPU granted, DMA not granted.
REQ-026 In IDLE with both requesting and wait_cnt == MAX_WAIT: DMA granted, cpu_stall=1, next state DMA_ACK.
REQ-027 In DMA_ACK: dma_ack=1, dma_rdata holds the word captured on the DMA grant cycle; DMA never granted in this state; CPU request granted if present.
REQ-028 wait_cnt (4-bit): increments each cycle dma_req=1 and DMA not granted, saturating at MAX_WAIT; clears to 0 on DMA grant or when dma_req=0.
REQ-029 cpu_stall = CPU request present AND CPU not granted; never asserted without a CPU request.
REQ-030 dma_rdata captured from mem_rdata at the edge ending a DMA read grant; unchanged by DMA writes and at all other times.
REQ-031 cpu_read and cpu_write both high is illegal; arbiter treats it as a write.
REQ-032 Back-to-back DMA: a dma_req still high in DMA_ACK is treated as a new request only from the following IDLE cycle, so DMA maximum throughput is one access per 2 cycles.

Reset
REQ-033 While reset=1, state=IDLE, wait_cnt=0, dma_ack=0, dma_rdata=0; all mem_* strobes 0 and cpu_stall=0 regardless of requests.
REQ-034 Reset asserted during a DMA grant or DMA_ACK aborts it: no dma_ack is issued; a store already presented on mem_write at the aborting edge is not guaranteed.
REQ-035 Reset deassertion takes effect at the next rising edge; no request is granted in a cycle in which reset=1.

Verification
REQ-036 CPU only: cpu_write=1, addr 0x10, data 0xDEADBEEF -> mem_write=1, mem_addr=0x10, mem_wdata=0xDEADBEEF, cpu_stall=0 same cycle.
REQ-037 DMA only read: addr 0x20, mem holds 0x12345678 -> grant cycle mem_read=1; next cycle dma_ack=1, dma_rdata=0x12345678; following cycle dma_ack=0.
REQ-038 Contention, MAX_WAIT=4: CPU requests every cycle, dma_req held -> CPU granted 4 cycles, 5th cycle DMA granted with cpu_stall=1, 6th cycle dma_ack=1 and CPU granted, wait_cnt=0.
REQ-039 Back-to-back DMA: dma_req held through ack, no CPU -> grants on cycles 0, 2, 4; dma_ack on cycles 1, 3, 5.
REQ-040 Reset mid-DMA: reset asserted in grant cycle -> dma_ack never pulses, outputs 0 immediately, first post-reset request arbitrated as fresh IDLE.
REQ-041 Illegal cpu_read=cpu_write=1 -> mem_write=1, mem_read=0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Single-port data-memory arbiter between the CPU MEM stage and a DMA/loader port.
// CPU normally wins; a DMA request that has waited MAX_WAIT cycles takes one cycle from the CPU.
module mem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_ack,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        DMA_ACK = 1'b1
    } state_t;

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    state_t            state_r;
    state_t            state_nxt_s;
    logic [3:0]        wait_cnt_r;
    logic [DATA_W-1:0] dma_rdata_r;
    logic              cpu_req_s;
    logic              dma_win_s;
    logic              cpu_gnt_s;
    logic              dma_gnt_s;

    assign cpu_req_s = cpu_read | cpu_write;
    // DMA wins an IDLE cycle when the CPU is absent or the DMA has starved long enough
    assign dma_win_s = dma_req & (~cpu_req_s | (wait_cnt_r >= MAX_WAIT_C));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: an acknowledge phase always lasts exactly one cycle
    always_comb begin
        state_nxt_s = IDLE;
        case (state_r)
            IDLE: begin
                if (dma_gnt_s) begin
                    state_nxt_s = DMA_ACK;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            DMA_ACK: state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Grant decision and memory-port muxing
    always_comb begin
        cpu_gnt_s = 1'b0;
        dma_gnt_s = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        cpu_rdata = '0;
        if (reset) begin
            cpu_gnt_s = 1'b0;
            dma_gnt_s = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    dma_gnt_s = dma_win_s;
                    cpu_gnt_s = cpu_req_s & ~dma_win_s;
                end
                DMA_ACK: begin
                    dma_gnt_s = 1'b0;
                    cpu_gnt_s = cpu_req_s;
                end
                default: begin
                    dma_gnt_s = 1'b0;
                    cpu_gnt_s = 1'b0;
                end
            endcase
        end

        if (dma_gnt_s) begin
            mem_read  = ~dma_we;
            mem_write = dma_we;
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
        end else if (cpu_gnt_s) begin
            // simultaneous read and write is resolved as a write
            mem_read  = cpu_read & ~cpu_write;
            mem_write = cpu_write;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            cpu_rdata = mem_rdata;
        end else begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
        end
    end

    assign cpu_stall = cpu_req_s & ~cpu_gnt_s & ~reset;
    assign dma_ack   = (state_r == DMA_ACK);
    assign dma_rdata = dma_rdata_r;

    // Starvation counter: counts ungranted DMA-pending cycles, saturating at MAX_WAIT
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_r <= 4'd0;
        end else if (!dma_req || dma_gnt_s) begin
            wait_cnt_r <= 4'd0;
        end else if (wait_cnt_r < MAX_WAIT_C) begin
            wait_cnt_r <= wait_cnt_r + 4'd1;
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // DMA read data capture at the end of a DMA read grant
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dma_rdata_r <= '0;
        end else if (dma_gnt_s && !dma_we) begin
            dma_rdata_r <= mem_rdata;
        end else begin
            dma_rdata_r <= dma_rdata_r;
        end
    end

endmodule
